// File: rtl/mul_add_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mul_add_pkg
// Purpose : Shared types and helpers for the shift-add multiply-accumulate
//           unit and the divider self-check wrapper that reuses it.
// Revision: 1.0 - initial release
// ============================================================================
package mul_add_pkg;

  // Controller states of the multiply-accumulate sequencer
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ADD  = 2'd2
  } state_t;

  // Step counter must be able to represent 0..width
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : mul_add_seq
// Purpose : Sequential unsigned multiply-accumulate, prod = a*b + addend.
//           Radix-2 shift-add: one multiplier bit per clock, then a single
//           accumulate cycle adding the zero-extended addend.
// Revision: 1.0 - initial release
// ============================================================================
module mul_add_seq
  import mul_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   addend,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int            CW        = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last_step;

  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] addend_lat;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   step_sum;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake outputs; start is only honoured in IDLE
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    last_step  = (count == LAST_STEP);
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) begin
          state_next = ADD;
        end
      end
      ADD: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Conditional add of the multiplicand into the high half, carry kept in MSB
  always_comb begin
    step_sum = {1'b0, hi} + (lo[0] ? {1'b0, a_lat} : '0);
  end

  // Datapath: latch operands, shift-add per step, final accumulate into prod
  always_ff @(posedge clk) begin
    if (rst) begin
      a_lat      <= '0;
      addend_lat <= '0;
      hi         <= '0;
      lo         <= '0;
      count      <= '0;
      prod       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_lat      <= a;
            addend_lat <= addend;
            hi         <= '0;
            lo         <= b;
            count      <= '0;
          end
        end
        RUN: begin
          // {carry, hi, lo} shifted right by one after the conditional add
          hi    <= step_sum[WIDTH:1];
          lo    <= {step_sum[0], lo[WIDTH-1:1]};
          count <= count + 1'b1;
        end
        ADD: begin
          prod <= {hi, lo} + {{WIDTH{1'b0}}, addend_lat};
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

  // Completion pulse, one cycle after the accumulate edge begins
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == ADD);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul_add_seq
// Purpose : Self-checking bench for mul_add_seq: cycle-level reference model
//           plus directed vectors with hand-computed results.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mul_add_seq;

  localparam int W = 8;

  logic           clk    = 1'b0;
  logic           rst    = 1'b1;
  logic           start  = 1'b0;
  logic [W-1:0]   a      = '0;
  logic [W-1:0]   b      = '0;
  logic [W-1:0]   addend = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] prod;

  int checks = 0;
  int errors = 0;

  mul_add_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .addend (addend),
    .busy   (busy),
    .done   (done),
    .prod   (prod)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: an accepted request completes WIDTH+1 edges later with a*b+addend
  int          m_left    = 0;
  logic [31:0] m_pending = '0;
  logic [31:0] m_prod    = '0;
  logic        m_done    = 1'b0;

  // Advance the model on each edge, then compare DUT outputs just after it
  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_prod = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_prod = m_pending;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_pending = 32'(a) * 32'(b) + 32'(addend);
        m_left    = W + 1;
      end
    end
    #1;
    check("model busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    check("model done", {31'd0, done}, {31'd0, m_done});
    check("model prod", {16'd0, prod}, m_prod);
    check("busy&done exclusive", {31'd0, busy & done}, 32'd0);
  end

  // Raise start for one edge with the given operands
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W-1:0] tadd);
    @(negedge clk);
    a      = ta;
    b      = tb;
    addend = tadd;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Wait (bounded) for done; reports negedges waited and busy cycles seen
  task automatic wait_done(input string name, output int cyc, output int busy_cycles);
    cyc         = 0;
    busy_cycles = 0;
    while (!done && cyc < 25) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      cyc++;
    end
    if (!done) check({name, " timeout"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [W-1:0] tadd, input logic [31:0] expected, output int busy_cycles);
    int cyc;
    issue(ta, tb, tadd);
    wait_done(name, cyc, busy_cycles);
    check(name, {16'd0, prod}, expected);
  endtask

  initial begin
    int bc;
    int cyc;
    int ndone;
    logic [W-1:0] m;
    logic [W-1:0] q;
    logic [W-1:0] r;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset prod", {16'd0, prod}, 32'd0);
    rst = 1'b0;

    // Basic product and busy duration
    run_op("13*11", 8'd13, 8'd11, 8'd0, 32'd143, bc);
    check("13*11 busy cycles", bc, 32'd9);

    // Extremes and the divider example
    run_op("255*255+255", 8'd255, 8'd255, 8'd255, 32'd65280, bc);
    run_op("0*200+7", 8'd0, 8'd200, 8'd7, 32'd7, bc);
    run_op("200*0+0", 8'd200, 8'd0, 8'd0, 32'd0, bc);
    run_op("7*18+2", 8'd7, 8'd18, 8'd2, 32'd128, bc);

    // Divider round-trip sample: Q*M + R with R < M reconstructs the dividend
    for (int i = 0; i < 100; i++) begin
      m = W'(1 + (i * 53) % 255);
      q = (i == 0) ? 8'd0 : (i == 1) ? 8'd255 : W'((i * 97 + i / 3) % 256);
      r = W'((i * 31) % int'(m));
      run_op("divider round-trip", m, q, r, 32'(q) * 32'(m) + 32'(r), bc);
    end

    // Starts while busy and mid-run operand changes are ignored
    issue(8'd3, 8'd5, 8'd1);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1 || i == 2) begin
        start = 1'b1;
        a     = 8'd200;
        b     = 8'd200;
      end else begin
        start = 1'b0;
      end
      if (i == 4) begin
        a = 8'd99;
        b = 8'd99;
      end
      if (done) ndone++;
      @(negedge clk);
    end
    check("busy-start done count", ndone, 32'd1);
    check("busy-start prod", {16'd0, prod}, 32'd16);

    // Back-to-back: start held in the done cycle
    issue(8'd2, 8'd3, 8'd0);
    wait_done("b2b first", cyc, bc);
    check("b2b first prod", {16'd0, prod}, 32'd6);
    a     = 8'd4;
    b     = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b second", cyc, bc);
    check("b2b done spacing", cyc + 1, 32'd10);
    check("b2b second prod", {16'd0, prod}, 32'd20);

    // Reset during RUN step 4 aborts with no done
    issue(8'd9, 8'd9, 8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort prod", {16'd0, prod}, 32'd0);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort no done", ndone, 32'd0);
    run_op("6*9+1", 8'd6, 8'd9, 8'd1, 32'd55, bc);

    // Reset clears a stale result; start is not accepted while rst is high
    run_op("13*11 again", 8'd13, 8'd11, 8'd0, 32'd143, bc);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("stale reset prod", {16'd0, prod}, 32'd0);
    check("stale reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("start during reset", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("start after reset", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done("post-reset op", cyc, bc);
    check("post-reset prod", {16'd0, prod}, 32'd143);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
